// File: rtl/cr_prefix_fe_acc_pkg.sv
// rtl/cr_prefix_fe_acc_pkg.sv - shared types for the prefix feature match accumulator
package cr_prefix_fe_acc_pkg;

  localparam int FE_CNT_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } fe_acc_state_e;

  // Result fields are sized for the widest supported counter; narrower builds use the low bits.
  typedef struct packed {
    logic [FE_CNT_W-1:0] match_cnt;
    logic [FE_CNT_W-1:0] byte_cnt;
    logic                ovf;
    logic                is_short;
    logic                hit;
  } fe_acc_res_t;

endpackage

// File: rtl/cr_prefix_fe_acc_sat_cnt.sv
// rtl/cr_prefix_fe_acc_sat_cnt.sv - saturating up-counter with clear and at-max flag
module cr_prefix_fe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_nxt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = &cnt_q;

  // cnt_nxt is the value including this cycle's increment, even when clr discards it.
  always_comb begin
    cnt_nxt = cnt_q;
    if (inc && !at_max) begin
      cnt_nxt = cnt_q + W'(1);
    end
    cnt_d = clr ? '0 : cnt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cr_prefix_fe_acc.sv
// rtl/cr_prefix_fe_acc.sv - per-feature match/byte accumulator with valid/ready result
// Optional threshold compare (fe_thresh/fe_hit) built when FE_ACC_THRESH_EN is defined.
module cr_prefix_fe_acc
  import cr_prefix_fe_acc_pkg::*;
#(
  parameter int CNT_W   = FE_CNT_W,
  parameter int LEN_MIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fe_char_match,
  input  logic             fe_char_vld_d,
  input  logic             fe_eot_d,
  output logic             fe_acc_ready,
  output logic             fe_res_valid,
  input  logic             fe_res_ready,
  output logic [CNT_W-1:0] fe_res_match_cnt,
  output logic [CNT_W-1:0] fe_res_byte_cnt,
  output logic             fe_res_ovf,
`ifdef FE_ACC_THRESH_EN
  output logic             fe_hit,
  input  logic [CNT_W-1:0] fe_thresh,
`endif
  output logic             fe_res_short
);

  localparam logic [CNT_W-1:0] LEN_MIN_V = CNT_W'(LEN_MIN);

  fe_acc_state_e state_q, state_d;
  fe_acc_res_t   res_q, res_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic             accept;
  logic             eot_acc;
  logic             match_inc;
  logic             ovf_now;
  logic             hit_nxt;
  logic [CNT_W-1:0] match_nxt;
  logic [CNT_W-1:0] byte_nxt;
  logic             match_max;
  logic             byte_max;

  // Ready passes the consumer's ready straight through so a back-to-back record loses no cycle.
  assign fe_acc_ready = (state_q == ACCUM) | (valid_q & fe_res_ready);
  assign accept       = fe_char_vld_d & fe_acc_ready;
  assign eot_acc      = accept & fe_eot_d;
  assign match_inc    = accept & fe_char_match;

  cr_prefix_fe_sat_cnt #(.W(CNT_W)) u_match_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (eot_acc),
    .inc     (match_inc),
    .cnt_nxt (match_nxt),
    .at_max  (match_max)
  );

  cr_prefix_fe_sat_cnt #(.W(CNT_W)) u_byte_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (eot_acc),
    .inc     (accept),
    .cnt_nxt (byte_nxt),
    .at_max  (byte_max)
  );

`ifdef FE_ACC_THRESH_EN
  assign hit_nxt = (match_nxt >= fe_thresh);
  assign fe_hit  = res_q.hit;
`else
  logic unused_hit;
  assign hit_nxt    = 1'b0;
  assign unused_hit = res_q.hit;
`endif

  always_comb begin
    ovf_now = ovf_q | (accept & byte_max) | (match_inc & match_max);
    state_d = state_q;
    res_d   = res_q;
    valid_d = valid_q;
    ovf_d   = ovf_now;
    if (eot_acc) begin
      res_d.match_cnt = FE_CNT_W'(match_nxt);
      res_d.byte_cnt  = FE_CNT_W'(byte_nxt);
      res_d.ovf       = ovf_now;
      res_d.is_short  = (byte_nxt < LEN_MIN_V);
      res_d.hit       = hit_nxt;
      valid_d         = 1'b1;
      ovf_d           = 1'b0;
      state_d         = OUT;
    end else if ((state_q == OUT) && fe_res_ready) begin
      valid_d = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fe_res_valid     = valid_q;
  assign fe_res_match_cnt = res_q.match_cnt[CNT_W-1:0];
  assign fe_res_byte_cnt  = res_q.byte_cnt[CNT_W-1:0];
  assign fe_res_ovf       = res_q.ovf;
  assign fe_res_short     = res_q.is_short;

endmodule

// File: tb/tb_cr_prefix_fe_acc.sv
// tb/tb_cr_prefix_fe_acc.sv - self-checking bench for cr_prefix_fe_acc
module tb_cr_prefix_fe_acc;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] b;
    logic        ovf;
    logic        sh;
  } res_t;

  typedef struct {
    int          nb;
    logic [15:0] pat;
    logic [15:0] exp_m;
    logic [15:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic match = 1'b0, vld = 1'b0, eot = 1'b0, res_ready = 1'b0;
  logic acc_ready, res_valid, res_ovf, res_short;
  logic [15:0] res_m, res_b;
  logic v4 = 1'b0, m4 = 1'b0, e4 = 1'b0, rr4 = 1'b1;
  logic ar4, rv4, ov4, sh4;
  logic [3:0] mc4, bc4;
`ifdef FE_ACC_THRESH_EN
  logic hit, hit4;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cr_prefix_fe_acc #(.CNT_W(16), .LEN_MIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .fe_char_match(match), .fe_char_vld_d(vld), .fe_eot_d(eot),
    .fe_acc_ready(acc_ready), .fe_res_valid(res_valid), .fe_res_ready(res_ready),
    .fe_res_match_cnt(res_m), .fe_res_byte_cnt(res_b), .fe_res_ovf(res_ovf),
`ifdef FE_ACC_THRESH_EN
    .fe_hit(hit), .fe_thresh(16'd3),
`endif
    .fe_res_short(res_short)
  );

  cr_prefix_fe_acc #(.CNT_W(4), .LEN_MIN(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .fe_char_match(m4), .fe_char_vld_d(v4), .fe_eot_d(e4),
    .fe_acc_ready(ar4), .fe_res_valid(rv4), .fe_res_ready(rr4),
    .fe_res_match_cnt(mc4), .fe_res_byte_cnt(bc4), .fe_res_ovf(ov4),
`ifdef FE_ACC_THRESH_EN
    .fe_hit(hit4), .fe_thresh(4'd3),
`endif
    .fe_res_short(sh4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Hold one byte until the accumulator takes it; returns one tick after the accepting edge.
  task automatic send(input logic m, input logic e);
    logic ok;
    int   guard;
    vld = 1'b1; match = m; eot = e;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = acc_ready;
      sync();
      guard++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    vld = 1'b0; match = 1'b0; eot = 1'b0;
  endtask

  task automatic push(input int m, input int b);
    exp_q.push_back('{m: 16'(m), b: 16'(b), ovf: 1'b0, sh: 1'b0});
  endtask

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {30'd0, res_m, res_b, res_ovf, res_short}, 64'd0);
      end else begin
        chk("result", {30'd0, res_m, res_b, res_ovf, res_short}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    vec_t vt[5];
    int   t0;
    vt[0] = '{nb: 5, pat: 16'b01101,   exp_m: 16'd3, exp_b: 16'd5};
    vt[1] = '{nb: 1, pat: 16'b0,       exp_m: 16'd0, exp_b: 16'd1};
    vt[2] = '{nb: 3, pat: 16'b111,     exp_m: 16'd3, exp_b: 16'd3};
    vt[3] = '{nb: 8, pat: 16'hA5,      exp_m: 16'd4, exp_b: 16'd8};
    vt[4] = '{nb: 2, pat: 16'b00,      exp_m: 16'd0, exp_b: 16'd2};

    repeat (3) @(negedge clk);
    chk("rst_acc_ready", acc_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", {res_m, res_b, res_ovf, res_short}, 0);
    chk("rst4_ready_valid", {ar4, rv4}, 2'b10);
    sync();
    rst_n = 1'b1;
    res_ready = 1'b1;
    sync();

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].nb; k++) begin
        send(vt[i].pat[k], k == vt[i].nb - 1);
      end
      push(vt[i].exp_m, vt[i].exp_b);
      @(negedge clk);
      chk("latency_valid", res_valid, 1);
      sync();
    end

    // Consumer stalls while upstream keeps offering the next record's first byte.
    res_ready = 1'b0;
    send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(0, 1);
    push(3, 5);
    vld = 1'b1; match = 1'b1; eot = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ready_valid", {acc_ready, res_valid}, 2'b01);
      chk("stall_result", {res_m, res_b}, {16'd3, 16'd5});
    end
    sync();
    res_ready = 1'b1;
    send(1, 0);
    send(0, 1);
    push(1, 2);
    sync();

    // Back-to-back single-byte records must stream at one per clock.
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      send(1, 1);
      push(1, 1);
    end
    chk("b2b_cycles", 64'(cyc - t0), 64'd6);
    repeat (2) sync();

    // Reset while a result is pending: it must vanish.
    res_ready = 1'b0;
    send(1, 1);
    @(negedge clk);
    chk("pending_valid", res_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid_ready", {res_valid, acc_ready}, 2'b01);
    sync();
    rst_n = 1'b1;
    res_ready = 1'b1;

    // Reset three bytes into a record: the next record counts from scratch.
    send(1, 0); send(1, 0); send(0, 0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    send(1, 0); send(1, 1);
    push(2, 2);
    repeat (2) sync();

`ifdef FE_ACC_THRESH_EN
    send(1, 0); send(1, 1);
    push(2, 2);
    @(negedge clk);
    chk("hit_below", hit, 0);
    sync();
    send(1, 0); send(1, 0); send(1, 1);
    push(3, 3);
    @(negedge clk);
    chk("hit_at", hit, 1);
    sync();
`endif

    // Narrow instance: counters saturate at 15 and the sticky overflow clears per record.
    for (int k = 0; k < 20; k++) begin
      v4 = 1'b1; m4 = 1'b1; e4 = (k == 19);
      sync();
    end
    v4 = 1'b0; m4 = 1'b0; e4 = 1'b0;
    @(negedge clk);
    chk("sat4_result", {rv4, mc4, bc4, ov4, sh4}, {1'b1, 4'd15, 4'd15, 1'b1, 1'b0});
    sync();
    v4 = 1'b1; m4 = 1'b1; e4 = 1'b0;
    sync();
    m4 = 1'b0; e4 = 1'b1;
    sync();
    v4 = 1'b0; e4 = 1'b0;
    @(negedge clk);
    chk("next4_result", {rv4, mc4, bc4, ov4, sh4}, {1'b1, 4'd1, 4'd2, 1'b0, 1'b1});
    repeat (3) sync();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
